// File: rtl/mux_rr_nto1.sv
// N-to-1 registered multiplexer with fixed-select or round-robin channel choice.
// Optional MUX_RR_XFER_CNT_EN adds a saturating 16-bit output transfer counter (xfer_cnt).
module mux_rr_nto1 #(
   parameter  int N  = 8,
   parameter  int W  = 8,
   localparam int SW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   input  logic            mode,
   input  logic [SW-1:0]   sel,
   output logic [W-1:0]    out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SW-1:0]   out_chan
`ifdef MUX_RR_XFER_CNT_EN
   ,
   output logic [15:0]     xfer_cnt
`endif
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t          state, state_nxt;
   logic            load;
   logic            grant_vld;
   logic [SW-1:0]   grant_idx;
   logic [W-1:0]    grant_data;
   logic [SW-1:0]   ptr;
   logic [SW-1:0]   ptr_nxt;

   // The output register may refill in the same cycle it drains.
   assign load = ~out_valid | out_ready;

   always_comb begin
      int idx;
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = 0;
      if (rst_n && load) begin
         if (!mode) begin
            if (int'(sel) < N && in_valid[sel]) begin
               grant_vld = 1'b1;
               grant_idx = sel;
            end
         end else begin
            for (int i = 0; i < N; i++) begin
               idx = int'(ptr) + i;
               if (idx >= N) idx = idx - N;
               if (!grant_vld && in_valid[idx]) begin
                  grant_vld = 1'b1;
                  grant_idx = SW'(idx);
               end
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (grant_vld) in_ready[grant_idx] = 1'b1;
   end

   assign grant_data = in_data[int'(grant_idx)*W +: W];
   assign ptr_nxt    = (grant_idx == SW'(N-1)) ? '0 : grant_idx + SW'(1);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (grant_vld) state_nxt = FULL;
      else if (load) state_nxt = EMPTY;
   end

   always_comb begin
      out_valid = (state == FULL);
   end

   // NOTE: the data path is reset too, because out_data/out_chan must read zero during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_chan <= '0;
         ptr      <= '0;
      end else if (grant_vld) begin
         out_data <= grant_data;
         out_chan <= grant_idx;
         if (mode) ptr <= ptr_nxt;
      end
   end

`ifdef MUX_RR_XFER_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         xfer_cnt <= '0;
      else if (out_valid && out_ready && xfer_cnt != 16'hFFFF)
         xfer_cnt <= xfer_cnt + 16'd1;
   end
`endif

endmodule

// File: doc/mux_rr_nto1.md
MUX_RR_NTO1 -- requirements
Module: mux_rr_nto1

Interface
REQ-001 Parameter N, default 8, number of input channels (legal 2..32).
REQ-002 Parameter W, default 8, data width per channel (legal 1..64).
REQ-003 Derived localparam SW = $clog2(N), select/channel-index width; not overridable.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  N*W  channel k occupies bits [k*W +: W].
REQ-007 in_valid  input  N  per-channel data-valid.
REQ-008 in_ready  output  N  per-channel accept strobe; a word transfers on in_valid[k] & in_ready[k].
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin scan.
REQ-010 sel  input  SW  channel index used when mode=0.
REQ-011 out_data  output  W  registered selected word.
REQ-012 out_valid  output  1  out_data holds an untaken word.
REQ-013 out_ready  input  1  downstream accept; transfer on out_valid & out_ready.
REQ-014 out_chan  output  SW  index of the channel that supplied out_data.

Function
REQ-015 The block SHALL hold a single output register, with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 The block SHALL assert load = ~out_valid | out_ready, and grant at most one channel per cycle, only when load=1.
REQ-017 In mode=0, the block SHALL grant channel sel when in_valid[sel]=1 and sel<N; if sel>=N, no channel is granted.
REQ-018 In mode=1, the block SHALL grant the first channel with in_valid set, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-019 in_ready SHALL be combinational: one-hot at the granted channel, all-zero when there is no grant or load=0.
REQ-020 On a grant, the block SHALL register in_data[k], set out_chan=k and out_valid=1 at the next edge; latency is 1 cycle.
REQ-021 On a mode=1 grant of channel k, ptr SHALL become k+1, wrapping from N-1 to 0; mode=0 grants SHALL leave ptr unchanged.
REQ-022 On load=1 with no grant, out_valid SHALL go to 0 at the next edge; out_data and out_chan SHALL hold their values.
REQ-023 With FULL and out_ready=1, simultaneous drain and refill SHALL sustain one word per cycle with no bubble.
REQ-024 With FULL and out_ready=0, out_data, out_chan and out_valid SHALL stay stable and in_ready SHALL be all-zero.
REQ-025 Changes to mode or sel SHALL affect only the next grant, never a word already held.
REQ-026 in_valid without in_ready SHALL NOT alter state; no word is dropped or duplicated.

Reset
REQ-027 While rst_n=0, out_valid=0, out_data=0, out_chan=0 and ptr=0, taking effect immediately without a clock edge.
REQ-028 Reset asserted while FULL SHALL discard the held word; there is no grant in the first cycle after deassertion unless an input is valid.
REQ-029 in_ready SHALL be all-zero while rst_n=0.

Configuration
REQ-030 Macro MUX_RR_XFER_CNT_EN, when defined, SHALL add output xfer_cnt [15:0]: a count of out-side transfers that saturates at 16'hFFFF and resets to 0.
REQ-031 Without MUX_RR_XFER_CNT_EN, the xfer_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Reset: with N=8, W=8, rst_n=0 mid-transfer holding 8'hA5 -> out_valid=0, out_data=0 and in_ready=0 immediately; after release, the first grant is from ptr=0.
REQ-033 Fixed: mode=0, sel=5, in_valid=8'hFF, out_ready=1 -> in_ready=8'h20 each cycle; out_data equals channel 5's word one cycle later; out_chan=5.
REQ-034 Round-robin: mode=1, in_valid=8'b1000_0101 held, out_ready=1 -> grant order 0, 2, 7, 0, 2, covering the wrap from 7 to 0.
REQ-035 Backpressure: FULL with 8'h3C, out_ready=0 for 4 cycles -> out_data=8'h3C stable and in_ready=0; out_ready=1 -> next word follows with no bubble.
REQ-036 Out of range: N=6, mode=0, sel=7 -> in_ready=0 and out_valid falls to 0 after drain.
REQ-037 Counter: with MUX_RR_XFER_CNT_EN, 70000 back-to-back transfers -> xfer_cnt=16'hFFFF and holds.
